lmg_move_packer: RTL and testbench

- Producer end of the legal-move-generator result FIFO.
- Accepts single 18-bit moves from the LMG generation units through a valid/ready handshake.
- Packs 8 moves per 152-bit word, flushes a padded partial word and appends an all-invalid terminator word. The downstream controller pops words via rden/fifoOut and stops when it sees the terminator.
- Also signals done, which the controller waits on before it starts popping.

---
 rtl/chess_lmg_pkg.sv | 32 +++
 rtl/lmg_word_fifo.sv | 77 +++++++
 rtl/lmg_move_packer.sv | 123 ++++++++++++
 tb/tb_lmg_move_packer.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/chess_lmg_pkg.sv
// Shared constants, word layout helpers and FSM state type for the LMG result FIFO.
package chess_lmg_pkg;

  localparam int MOVE_W = 18;
  localparam int SLOTS  = 8;
  localparam int SLOT_W = MOVE_W + 1;
  localparam int WORD_W = SLOTS * SLOT_W;

  // Move fields are opaque to the packer; this layout is kept here for readers of the FIFO words.
  typedef struct packed {
    logic [5:0] from_sq;
    logic [5:0] to_sq;
    logic [2:0] promo;
    logic [2:0] flags;
  } lmg_move_t;

  typedef enum logic [2:0] {IDLE, PACK, FLUSH, TERM, DONE} lmg_state_e;

  function automatic int slot_lsb(input int k);
    return k * SLOT_W;
  endfunction

  function automatic logic [WORD_W-1:0] term_word();
    logic [WORD_W-1:0] w;
    w = '0;
    for (int k = 0; k < SLOTS; k++) w[slot_lsb(k) + MOVE_W] = 1'b1;
    return w;
  endfunction

  localparam logic [WORD_W-1:0] TERM_WORD = term_word();

endpackage

// File: rtl/lmg_word_fifo.sv
// Word FIFO between the move packer and the search controller.
// Output word is registered on pop; popping an empty FIFO presents the terminator word.
module lmg_word_fifo
  import chess_lmg_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clr,
  input  logic              push,
  input  logic [WORD_W-1:0] push_data,
  input  logic              pop,
  output logic [WORD_W-1:0] dout,
  output logic              empty,
  output logic              full
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WORD_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [WORD_W-1:0] dout_q, dout_d;
  logic              empty_q, empty_d;
  logic              do_pop;

  assign full   = (cnt_q == CW'(DEPTH));
  assign do_pop = pop && (cnt_q != '0);

  always_comb begin
    wr_d   = wr_q;
    rd_d   = rd_q;
    cnt_d  = cnt_q;
    dout_d = dout_q;
    if (clr) begin
      wr_d   = '0;
      rd_d   = '0;
      cnt_d  = '0;
      dout_d = TERM_WORD;
    end else begin
      if (push) wr_d = wr_q + 1'b1;
      if (pop) begin
        dout_d = do_pop ? mem_q[rd_q] : TERM_WORD;
        if (do_pop) rd_d = rd_q + 1'b1;
      end
      if (push && !do_pop)      cnt_d = cnt_q + CW'(1);
      else if (do_pop && !push) cnt_d = cnt_q - CW'(1);
    end
    empty_d = (cnt_d == '0);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_q    <= '0;
      rd_q    <= '0;
      cnt_q   <= '0;
      dout_q  <= TERM_WORD;
      empty_q <= 1'b1;
    end else begin
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      cnt_q   <= cnt_d;
      dout_q  <= dout_d;
      empty_q <= empty_d;
    end
  end

  // Storage needs no reset: only entries between the pointers are ever read.
  always_ff @(posedge clk) begin
    if (push && !clr) mem_q[wr_q] <= push_data;
  end

  assign dout  = dout_q;
  assign empty = empty_q;

endmodule

// File: rtl/lmg_move_packer.sv
// Packs accepted moves eight to a word, flushes the partial word and appends a terminator.
//   IDLE  | waiting for start
//   PACK  | accepting moves into the assembly word
//   FLUSH | pushing the padded partial word
//   TERM  | pushing the all-invalid terminator
//   DONE  | generation complete
module lmg_move_packer
  import chess_lmg_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              mv_valid,
  input  logic [MOVE_W-1:0] mv_data,
  output logic              mv_ready,
  input  logic              gen_done,
  input  logic              rden,
  output logic [WORD_W-1:0] fifoOut,
  output logic              fifoEmpty,
  output logic              done,
  output logic [7:0]        move_count
);
  localparam int SLOT_IW = $clog2(SLOTS);
  localparam logic [SLOT_IW-1:0] LAST_SLOT = SLOT_IW'(SLOTS - 1);

  lmg_state_e        state_q, state_d;
  logic [SLOT_IW-1:0] slot_q, slot_d;
  logic [WORD_W-1:0] asm_q, asm_d, filled_word, push_word;
  logic [7:0]        count_q, count_d;
  logic              push, fifo_full, accept;

  always_comb begin
    state_d     = state_q;
    slot_d      = slot_q;
    asm_d       = asm_q;
    count_d     = count_q;
    push        = 1'b0;
    push_word   = asm_q;
    mv_ready    = 1'b0;
    accept      = 1'b0;
    filled_word = asm_q;
    filled_word[slot_lsb(int'(slot_q)) +: SLOT_W] = {1'b0, mv_data};

    case (state_q)
      PACK: begin
        mv_ready = !((slot_q == LAST_SLOT) && fifo_full);
        accept   = mv_valid && mv_ready;
        if (accept) begin
          count_d = (count_q == 8'hFF) ? count_q : count_q + 8'd1;
          if (slot_q == LAST_SLOT) begin
            push      = 1'b1;
            push_word = filled_word;
            slot_d    = '0;
            asm_d     = TERM_WORD;
          end else begin
            slot_d = slot_q + 1'b1;
            asm_d  = filled_word;
          end
        end
        // A move accepted alongside gen_done is already folded into slot_d.
        if (gen_done) state_d = (slot_d != '0) ? FLUSH : TERM;
      end
      FLUSH: begin
        if (!fifo_full) begin
          push      = 1'b1;
          push_word = asm_q;
          slot_d    = '0;
          asm_d     = TERM_WORD;
          state_d   = TERM;
        end
      end
      TERM: begin
        if (!fifo_full) begin
          push      = 1'b1;
          push_word = TERM_WORD;
          state_d   = DONE;
        end
      end
      default: ;
    endcase

    if (start) begin
      state_d  = PACK;
      slot_d   = '0;
      asm_d    = TERM_WORD;
      count_d  = '0;
      push     = 1'b0;
      mv_ready = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      slot_q  <= '0;
      asm_q   <= TERM_WORD;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      slot_q  <= slot_d;
      asm_q   <= asm_d;
      count_q <= count_d;
    end
  end

  lmg_word_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .clr       (start),
    .push      (push),
    .push_data (push_word),
    .pop       (rden),
    .dout      (fifoOut),
    .empty     (fifoEmpty),
    .full      (fifo_full)
  );

  assign done       = (state_q == DONE);
  assign move_count = count_q;

endmodule

// File: tb/tb_lmg_move_packer.sv
// Scoreboard bench for lmg_move_packer with a two-word FIFO.
module tb_lmg_move_packer;

  logic         clk = 1'b0;
  logic         reset, start, mv_valid, gen_done, rden;
  logic [17:0]  mv_data;
  logic         mv_ready, fifoEmpty, done;
  logic [151:0] fifoOut;
  logic [7:0]   move_count;

  int n_tests = 0;
  int n_fail  = 0;

  logic [151:0] term_w;
  logic [151:0] cur_w;
  int           cur_n;
  logic [151:0] expq [$];

  lmg_move_packer #(.DEPTH(2)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .mv_valid   (mv_valid),
    .mv_data    (mv_data),
    .mv_ready   (mv_ready),
    .gen_done   (gen_done),
    .rden       (rden),
    .fifoOut    (fifoOut),
    .fifoEmpty  (fifoEmpty),
    .done       (done),
    .move_count (move_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [151:0] act, input logic [151:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every pop is checked against the next expected word.
  always @(posedge clk) begin
    if (rden && reset) begin
      #1;
      if (expq.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL pop_unexpected: got %h expected no pop", fifoOut);
      end else begin
        chk("pop_word", fifoOut, expq.pop_front());
      end
    end
  end

  task automatic model_clear();
    expq.delete();
    cur_w = term_w;
    cur_n = 0;
  endtask

  task automatic model_move(input logic [17:0] d);
    cur_w[cur_n*19 +: 19] = {1'b0, d};
    cur_n++;
    if (cur_n == 8) begin
      expq.push_back(cur_w);
      cur_w = term_w;
      cur_n = 0;
    end
  endtask

  task automatic model_gen_done();
    if (cur_n > 0) expq.push_back(cur_w);
    cur_w = term_w;
    cur_n = 0;
    expq.push_back(term_w);
  endtask

  task automatic send(input logic [17:0] d, input bit gd);
    int t;
    t = 0;
    @(negedge clk);
    mv_valid = 1'b1;
    mv_data  = d;
    gen_done = 1'b0;
    #1;
    while (!mv_ready && t < 100) begin
      @(negedge clk);
      #1;
      t++;
    end
    if (!mv_ready) begin
      n_tests++;
      n_fail++;
      $display("FAIL send_timeout: got mv_ready=0 expected 1 for move %h", d);
      mv_valid = 1'b0;
    end else begin
      gen_done = gd;
      @(posedge clk);
      #1;
      mv_valid = 1'b0;
      gen_done = 1'b0;
      model_move(d);
      if (gd) model_gen_done();
    end
  endtask

  task automatic gen_done_only();
    @(negedge clk);
    gen_done = 1'b1;
    @(posedge clk);
    #1;
    gen_done = 1'b0;
    model_gen_done();
  endtask

  task automatic pop();
    @(negedge clk);
    rden = 1'b1;
    @(negedge clk);
    rden = 1'b0;
  endtask

  task automatic pop_empty();
    expq.push_back(term_w);
    pop();
  endtask

  task automatic do_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    model_clear();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    term_w = '0;
    for (int k = 0; k < 8; k++) term_w[19*k + 18] = 1'b1;
    model_clear();
    reset = 1'b0; start = 1'b0; mv_valid = 1'b0; mv_data = '0;
    gen_done = 1'b0; rden = 1'b0;

    // reset state
    repeat (2) @(negedge clk);
    #1;
    chk("rst_fifoOut", fifoOut, term_w);
    chk("rst_fifoEmpty", fifoEmpty, 1'b1);
    chk("rst_mv_ready", mv_ready, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_move_count", move_count, 8'd0);
    @(negedge clk);
    reset = 1'b1;

    // pop while empty right after reset
    pop_empty();
    #1;
    chk("empty_pop_fifoEmpty", fifoEmpty, 1'b1);

    // three-move generation
    do_start();
    send(18'h00A41, 1'b0);
    send(18'h00A82, 1'b0);
    send(18'h00AC3, 1'b1);
    @(negedge clk); #1; chk("three_done_g1", done, 1'b0);
    @(negedge clk); #1; chk("three_done_g2", done, 1'b0);
    @(negedge clk); #1; chk("three_done_g3", done, 1'b1);
    chk("three_move_count", move_count, 8'd3);
    chk("three_fifoEmpty", fifoEmpty, 1'b0);
    pop();
    pop();
    #1;
    chk("three_drained", fifoEmpty, 1'b1);

    // exactly eight moves, gen_done with the eighth
    do_start();
    for (int i = 0; i < 8; i++) send(18'h01000 + 18'(i), (i == 7));
    @(negedge clk); #1; chk("eight_done_g1", done, 1'b0);
    @(negedge clk); #1; chk("eight_done_g2", done, 1'b1);
    chk("eight_move_count", move_count, 8'd8);
    pop();
    pop();
    #1;
    chk("eight_drained", fifoEmpty, 1'b1);

    // zero moves
    do_start();
    gen_done_only();
    @(negedge clk); #1; chk("zero_done_g1", done, 1'b0);
    @(negedge clk); #1; chk("zero_done_g2", done, 1'b1);
    pop();
    #1;
    chk("zero_drained", fifoEmpty, 1'b1);
    pop_empty();

    // backpressure: two words fill the FIFO, third stalls at slot 7
    do_start();
    for (int i = 0; i < 23; i++) send(18'h10000 + 18'(i), 1'b0);
    @(negedge clk);
    mv_valid = 1'b1;
    mv_data  = 18'h10017;
    #1;
    chk("bp_stall_ready", mv_ready, 1'b0);
    chk("bp_stall_fifoEmpty", fifoEmpty, 1'b0);
    rden = 1'b1;
    @(negedge clk);
    rden = 1'b0;
    #1;
    chk("bp_resume_ready", mv_ready, 1'b1);
    gen_done = 1'b1;
    @(posedge clk);
    #1;
    mv_valid = 1'b0;
    gen_done = 1'b0;
    model_move(18'h10017);
    model_gen_done();
    repeat (3) begin
      pop();
      @(negedge clk);
    end
    @(negedge clk); #1;
    chk("bp_drained", fifoEmpty, 1'b1);
    chk("bp_done", done, 1'b1);
    chk("bp_move_count", move_count, 8'd24);

    // start while DONE with words unpopped
    do_start();
    send(18'h3FFFF, 1'b0);
    send(18'h00001, 1'b1);
    repeat (4) @(negedge clk);
    #1;
    chk("restart_pre_done", done, 1'b1);
    chk("restart_pre_fifoEmpty", fifoEmpty, 1'b0);
    do_start();
    #1;
    chk("restart_fifoEmpty", fifoEmpty, 1'b1);
    chk("restart_move_count", move_count, 8'd0);
    chk("restart_done", done, 1'b0);
    chk("restart_pack_ready", mv_ready, 1'b1);
    pop_empty();

    // async reset mid-PACK with moves pending
    do_start();
    for (int i = 0; i < 21; i++) send(18'h2AAA0 + 18'(i), 1'b0);
    pop();
    #1;
    chk("mid_pre_fifoEmpty", fifoEmpty, 1'b0);
    @(negedge clk);
    mv_valid = 1'b1;
    mv_data  = 18'h15555;
    #2;
    reset = 1'b0;
    #1;
    chk("async_fifoOut", fifoOut, term_w);
    chk("async_fifoEmpty", fifoEmpty, 1'b1);
    chk("async_mv_ready", mv_ready, 1'b0);
    chk("async_done", done, 1'b0);
    chk("async_move_count", move_count, 8'd0);
    @(negedge clk);
    reset = 1'b1;
    model_clear();
    #1;
    chk("idle_mv_ready", mv_ready, 1'b0);
    mv_valid = 1'b0;

    repeat (3) @(negedge clk);
    chk("scoreboard_drained", 152'(expq.size()), 152'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
